// File: rtl/serial_echo_pkg.sv
// Shared types and constants for the serial echo tester: FSM encoding, echo rule,
// error saturation and status-LED blink timing.
package serial_echo_pkg;

   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_LOAD    = 4'd1,
      ST_SEND    = 4'd2,
      ST_WAIT_TX = 4'd3,
      ST_WAIT_RX = 4'd4,
      ST_READ    = 4'd5,
      ST_CHECK   = 4'd6,
      ST_NEXT    = 4'd7,
      ST_FIN     = 4'd8
   } state_t;

   typedef enum logic [1:0] {
      LED_OFF  = 2'd0,
      LED_SLOW = 2'd1,
      LED_FAST = 2'd2,
      LED_ON   = 2'd3
   } led_mode_t;

   localparam logic [7:0]  ECHO_INCREMENT  = 8'h01;
   localparam logic [15:0] ERR_SAT         = 16'hFFFF;
   localparam logic [31:0] BLINK_SLOW_HALF = 32'd10_000_000;
   localparam logic [31:0] BLINK_FAST_HALF = 32'd2_500_000;

   // Up to two error events can land in one cycle (stray byte plus a check/timeout).
   function automatic logic [15:0] err_add_sat(input logic [15:0] cnt, input logic [1:0] inc);
      logic [16:0] sum;
      sum = {1'b0, cnt} + {15'd0, inc};
      return sum[16] ? ERR_SAT : sum[15:0];
   endfunction

endpackage

// File: rtl/led_blink_gen.sv
// Status LED pattern generator (off / slow blink / fast blink / on), active-high output.
// Only built with SERIAL_ECHO_TESTER_LED_EN defined.
`ifdef SERIAL_ECHO_TESTER_LED_EN
module led_blink_gen
   import serial_echo_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] mode,
   output logic       led
);

   logic [31:0] r_cnt;
   logic        r_phase;
   logic [31:0] w_half;

   assign w_half = (mode == LED_FAST) ? BLINK_FAST_HALF : BLINK_SLOW_HALF;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt   <= '0;
         r_phase <= 1'b0;
         led     <= 1'b0;
      end else begin
         // Steady modes park the blinker so a new blink starts in the lit phase.
         if (mode == LED_OFF || mode == LED_ON) begin
            r_cnt   <= '0;
            r_phase <= 1'b1;
         end else if (r_cnt >= w_half - 32'd1) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
         end else begin
            r_cnt <= r_cnt + 32'd1;
         end
         case (mode)
            LED_OFF: led <= 1'b0;
            LED_ON:  led <= 1'b1;
            default: led <= r_phase;
         endcase
      end
   end

endmodule
`endif

// File: rtl/serial_echo_tester.sv
// Host-side echo tester: sends a byte pattern over the quick_rs232 Tx handshake and
// expects each byte back +1. Define SERIAL_ECHO_TESTER_LED_EN for board LED outputs.
module serial_echo_tester
   import serial_echo_pkg::*;
#(
   parameter logic [15:0] BYTE_COUNT          = 16'd256,
   parameter logic [7:0]  PATTERN_START       = 8'h00,
   parameter logic [7:0]  PATTERN_STEP        = 8'h01,
   parameter logic [7:0]  RX_READ_HOLD        = 8'd16,
   parameter logic [31:0] RESP_TIMEOUT_CYCLES = 32'd100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        tx_transaction,
   output logic [7:0]  tx_data,
   output logic        tx_data_ready,
   input  logic        tx_data_copied,
   input  logic        tx_busy,
   input  logic        rx_byte_received,
   input  logic [7:0]  rx_data,
   input  logic        rx_err,
   output logic        rx_read,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [15:0] sent_count,
   output logic [15:0] err_count,
   output logic [7:0]  last_received
`ifdef SERIAL_ECHO_TESTER_LED_EN
   ,
   output logic [7:0]  led_bus,
   output logic        status_led
`endif
);

   state_t      r_state;
   logic        r_start_d;
   logic        r_rx_d;
   logic [7:0]  r_pattern;
   logic [7:0]  r_expected;
   logic [31:0] r_timeout_cnt;
   logic [7:0]  r_hold_cnt;
   logic        r_rx_err_flag;
   logic        r_tx_transaction;
   logic [7:0]  r_tx_data;
   logic        r_tx_data_ready;
   logic        r_rx_read;
   logic        r_busy;
   logic        r_done;
   logic        r_pass;
   logic [15:0] r_sent_count;
   logic [15:0] r_err_count;
   logic [7:0]  r_last_received;

   logic        w_start_edge;
   logic        w_rx_edge;
   logic        w_stray;
   logic        w_timeout_hit;
   logic        w_check_err;
   logic [1:0]  w_err_inc;
   logic [15:0] w_err_next;

   assign w_start_edge  = start & ~r_start_d;
   assign w_rx_edge     = rx_byte_received & ~r_rx_d;
   assign w_stray       = w_rx_edge && (r_state != ST_WAIT_RX);
   // A byte arriving on the last timeout cycle still counts as received.
   assign w_timeout_hit = (r_state == ST_WAIT_RX) && !w_rx_edge &&
                          (r_timeout_cnt == RESP_TIMEOUT_CYCLES - 32'd1);
   assign w_check_err   = (r_state == ST_CHECK) &&
                          (r_rx_err_flag || (r_last_received != r_expected));
   assign w_err_inc     = {1'b0, w_stray} + {1'b0, w_timeout_hit | w_check_err};
   assign w_err_next    = err_add_sat(r_err_count, w_err_inc);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state          <= ST_IDLE;
         r_start_d        <= 1'b0;
         r_rx_d           <= 1'b0;
         r_pattern        <= PATTERN_START;
         r_expected       <= '0;
         r_timeout_cnt    <= '0;
         r_hold_cnt       <= '0;
         r_rx_err_flag    <= 1'b0;
         r_tx_transaction <= 1'b0;
         r_tx_data        <= '0;
         r_tx_data_ready  <= 1'b0;
         r_rx_read        <= 1'b0;
         r_busy           <= 1'b0;
         r_done           <= 1'b0;
         r_pass           <= 1'b0;
         r_sent_count     <= '0;
         r_err_count      <= '0;
         r_last_received  <= '0;
      end else begin
         r_start_d   <= start;
         r_rx_d      <= rx_byte_received;
         r_err_count <= w_err_next;
         r_pass      <= r_done && (w_err_next == 16'd0);
         case (r_state)
            ST_IDLE: begin
               if (w_start_edge) begin
                  r_sent_count <= '0;
                  r_err_count  <= '0;
                  r_done       <= 1'b0;
                  r_pass       <= 1'b0;
                  r_pattern    <= PATTERN_START;
                  r_busy       <= 1'b1;
                  r_state      <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               r_tx_transaction <= 1'b1;
               r_tx_data        <= r_pattern;
               r_expected       <= r_pattern + ECHO_INCREMENT;
               r_state          <= ST_SEND;
            end
            ST_SEND: begin
               if (r_tx_data_ready && tx_data_copied) begin
                  r_tx_data_ready <= 1'b0;
                  r_state         <= ST_WAIT_TX;
               end else begin
                  r_tx_data_ready <= 1'b1;
               end
            end
            ST_WAIT_TX: begin
               if (!tx_busy) begin
                  r_timeout_cnt <= '0;
                  r_state       <= ST_WAIT_RX;
               end
            end
            ST_WAIT_RX: begin
               if (w_rx_edge) begin
                  r_rx_read  <= 1'b1;
                  r_hold_cnt <= '0;
                  r_state    <= ST_READ;
               end else if (w_timeout_hit) begin
                  r_state <= ST_NEXT;
               end else begin
                  r_timeout_cnt <= r_timeout_cnt + 32'd1;
               end
            end
            ST_READ: begin
               // Sample on the same edge that drops rx_read, after the full hold.
               if (r_hold_cnt == RX_READ_HOLD - 8'd1) begin
                  r_rx_read       <= 1'b0;
                  r_last_received <= rx_data;
                  r_rx_err_flag   <= rx_err;
                  r_state         <= ST_CHECK;
               end else begin
                  r_hold_cnt <= r_hold_cnt + 8'd1;
               end
            end
            ST_CHECK: r_state <= ST_NEXT;
            ST_NEXT: begin
               r_sent_count <= r_sent_count + 16'd1;
               if (r_sent_count + 16'd1 == BYTE_COUNT) begin
                  r_state <= ST_FIN;
               end else begin
                  r_pattern <= r_pattern + PATTERN_STEP;
                  r_state   <= ST_LOAD;
               end
            end
            ST_FIN: begin
               r_tx_transaction <= 1'b0;
               r_done           <= 1'b1;
               r_pass           <= (w_err_next == 16'd0);
               r_busy           <= 1'b0;
               r_state          <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign tx_transaction = r_tx_transaction;
   assign tx_data        = r_tx_data;
   assign tx_data_ready  = r_tx_data_ready;
   assign rx_read        = r_rx_read;
   assign busy           = r_busy;
   assign done           = r_done;
   assign pass           = r_pass;
   assign sent_count     = r_sent_count;
   assign err_count      = r_err_count;
   assign last_received  = r_last_received;

`ifdef SERIAL_ECHO_TESTER_LED_EN
   led_mode_t w_led_mode;
   logic      w_led;

   always_comb begin
      w_led_mode = LED_OFF;
      if (r_busy)      w_led_mode = LED_SLOW;
      else if (r_pass) w_led_mode = LED_ON;
      else if (r_done) w_led_mode = LED_FAST;
   end

   led_blink_gen u_led_blink_gen (
      .clk  (clk),
      .rst  (rst),
      .mode (w_led_mode),
      .led  (w_led)
   );

   assign led_bus    = ~r_err_count[7:0];
   assign status_led = ~w_led;
`endif

endmodule

// File: tb/tb_serial_echo_tester.sv
// Directed bench: echo-board models answer each byte +1 with optional corruption,
// drop, rx_err or stray edges; a second instance covers pattern wrap-around.
module tb_serial_echo_tester;

   logic        clk;
   logic        rst;
   logic        start;
   logic        tx_data_copied;
   logic        tx_busy;
   logic        echo_rx;
   logic        stray_rx;
   logic        rx_byte_received;
   logic [7:0]  rx_data;
   logic        rx_err;
   logic        tx_transaction;
   logic [7:0]  tx_data;
   logic        tx_data_ready;
   logic        rx_read;
   logic        busy;
   logic        done;
   logic        pass;
   logic [15:0] sent_count;
   logic [15:0] err_count;
   logic [7:0]  last_received;

   logic        w_start;
   logic        w_copied;
   logic        w_rxv;
   logic [7:0]  w_rxd;
   logic        w_tx_transaction;
   logic [7:0]  w_tx_data;
   logic        w_tx_ready;
   logic        w_rx_read;
   logic        w_busy;
   logic        w_done;
   logic        w_pass;
   logic [15:0] w_sent;
   logic [15:0] w_err;
   logic [7:0]  w_last;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          echo_idx;
   int          drop_idx = -1;
   int          corrupt_idx = -1;
   int          err_idx = -1;
   int          rd_hold_last;
   logic [7:0]  tx_log [0:7];
   logic [7:0]  w_log [0:7];

   assign rx_byte_received = echo_rx | stray_rx;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   serial_echo_tester #(
      .BYTE_COUNT          (16'd4),
      .PATTERN_START       (8'h00),
      .PATTERN_STEP        (8'h01),
      .RX_READ_HOLD        (8'd4),
      .RESP_TIMEOUT_CYCLES (32'd1000)
   ) u_dut (
      .clk              (clk),
      .rst              (rst),
      .start            (start),
      .tx_transaction   (tx_transaction),
      .tx_data          (tx_data),
      .tx_data_ready    (tx_data_ready),
      .tx_data_copied   (tx_data_copied),
      .tx_busy          (tx_busy),
      .rx_byte_received (rx_byte_received),
      .rx_data          (rx_data),
      .rx_err           (rx_err),
      .rx_read          (rx_read),
      .busy             (busy),
      .done             (done),
      .pass             (pass),
      .sent_count       (sent_count),
      .err_count        (err_count),
      .last_received    (last_received)
   );

   serial_echo_tester #(
      .BYTE_COUNT          (16'd2),
      .PATTERN_START       (8'hFF),
      .PATTERN_STEP        (8'h01),
      .RX_READ_HOLD        (8'd2),
      .RESP_TIMEOUT_CYCLES (32'd1000)
   ) u_dut_wrap (
      .clk              (clk),
      .rst              (rst),
      .start            (w_start),
      .tx_transaction   (w_tx_transaction),
      .tx_data          (w_tx_data),
      .tx_data_ready    (w_tx_ready),
      .tx_data_copied   (w_copied),
      .tx_busy          (1'b0),
      .rx_byte_received (w_rxv),
      .rx_data          (w_rxd),
      .rx_err           (1'b0),
      .rx_read          (w_rx_read),
      .busy             (w_busy),
      .done             (w_done),
      .pass             (w_pass),
      .sent_count       (w_sent),
      .err_count        (w_err),
      .last_received    (w_last)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while (!done && n < 20000) begin
         @(negedge clk);
         n++;
      end
      check_val({tag, "_done"}, 32'(done), 32'd1);
   endtask

   task automatic check_seq(input string tag);
      for (int i = 0; i < 4; i++)
         check_val($sformatf("%s_tx%0d", tag, i), 32'(tx_log[i]), 32'(i));
   endtask

   // Echo board for the main instance: copies after 3 cycles, shifts for 20, answers 100 later.
   initial begin
      logic [7:0] b;
      int n;
      tx_data_copied = 1'b0;
      tx_busy        = 1'b0;
      echo_rx        = 1'b0;
      rx_data        = 8'h00;
      rx_err         = 1'b0;
      rd_hold_last   = 0;
      forever begin
         @(negedge clk);
         if (tx_data_ready && !rst) begin
            repeat (3) @(negedge clk);
            b = tx_data;
            if (echo_idx >= 0 && echo_idx < 8) tx_log[echo_idx] = b;
            tx_data_copied = 1'b1;
            tx_busy        = 1'b1;
            @(negedge clk);
            tx_data_copied = 1'b0;
            repeat (20) @(negedge clk);
            tx_busy = 1'b0;
            if (echo_idx != drop_idx) begin
               repeat (100) @(negedge clk);
               rx_data = (echo_idx == corrupt_idx) ? 8'h55 : b + 8'h01;
               rx_err  = (echo_idx == err_idx);
               echo_rx = 1'b1;
               n = 0;
               while (!rx_read && n < 2000) begin @(negedge clk); n++; end
               n = 0;
               while (rx_read && n < 2000) begin @(negedge clk); n++; end
               rd_hold_last = n;
               echo_rx = 1'b0;
               rx_err  = 1'b0;
            end
            echo_idx++;
         end
      end
   end

   // Echo board for the wrap-around instance: immediate copy, answer 30 cycles later.
   initial begin
      logic [7:0] wb;
      int wi;
      w_copied = 1'b0;
      w_rxv    = 1'b0;
      w_rxd    = 8'h00;
      wi       = 0;
      forever begin
         @(negedge clk);
         if (w_tx_ready && !rst) begin
            wb = w_tx_data;
            if (wi < 8) w_log[wi] = wb;
            w_copied = 1'b1;
            @(negedge clk);
            w_copied = 1'b0;
            repeat (30) @(negedge clk);
            w_rxd = wb + 8'h01;
            w_rxv = 1'b1;
            for (int n = 0; n < 500 && !w_rx_read; n++) @(negedge clk);
            for (int n = 0; n < 500 && w_rx_read; n++) @(negedge clk);
            w_rxv = 1'b0;
            wi++;
         end
      end
   end

   initial begin
      int n;
      rst      = 1'b1;
      start    = 1'b0;
      w_start  = 1'b0;
      stray_rx = 1'b0;
      echo_idx = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      check_val("rst_busy",     32'(busy), 32'd0);
      check_val("rst_done",     32'(done), 32'd0);
      check_val("rst_pass",     32'(pass), 32'd0);
      check_val("rst_tx_trans", 32'(tx_transaction), 32'd0);
      check_val("rst_tx_ready", 32'(tx_data_ready), 32'd0);
      check_val("rst_rx_read",  32'(rx_read), 32'd0);
      check_val("rst_tx_data",  32'(tx_data), 32'd0);
      check_val("rst_sent",     32'(sent_count), 32'd0);
      check_val("rst_err",      32'(err_count), 32'd0);
      check_val("rst_last",     32'(last_received), 32'd0);

      // Ideal echo; a second start mid-run must be ignored.
      echo_idx = 0;
      pulse_start();
      check_val("t1_busy", 32'(busy), 32'd1);
      repeat (150) @(negedge clk);
      pulse_start();
      wait_done("t1");
      check_seq("t1");
      check_val("t1_pass",     32'(pass), 32'd1);
      check_val("t1_sent",     32'(sent_count), 32'd4);
      check_val("t1_err",      32'(err_count), 32'd0);
      check_val("t1_last",     32'(last_received), 32'h04);
      check_val("t1_hold",     32'(rd_hold_last), 32'd4);
      check_val("t1_tx_trans", 32'(tx_transaction), 32'd0);
      check_val("t1_busy_end", 32'(busy), 32'd0);

      // Third byte comes back as 8'h55.
      repeat (5) @(negedge clk);
      corrupt_idx = 2;
      echo_idx = 0;
      pulse_start();
      check_val("t2_done_clr", 32'(done), 32'd0);
      check_val("t2_busy",     32'(busy), 32'd1);
      n = 0;
      while (sent_count != 16'd3 && n < 20000) begin @(negedge clk); n++; end
      check_val("t2_last_mid", 32'(last_received), 32'h55);
      check_val("t2_err_mid",  32'(err_count), 32'd1);
      wait_done("t2");
      check_val("t2_err",  32'(err_count), 32'd1);
      check_val("t2_pass", 32'(pass), 32'd0);
      check_val("t2_sent", 32'(sent_count), 32'd4);
      check_val("t2_last", 32'(last_received), 32'h04);
      corrupt_idx = -1;

      // Second byte never answered: timeout path.
      repeat (5) @(negedge clk);
      drop_idx = 1;
      echo_idx = 0;
      pulse_start();
      wait_done("t3");
      check_val("t3_err",  32'(err_count), 32'd1);
      check_val("t3_pass", 32'(pass), 32'd0);
      check_val("t3_sent", 32'(sent_count), 32'd4);
      check_val("t3_last", 32'(last_received), 32'h04);
      drop_idx = -1;

      // rx_err on the first byte, then a stray edge while the third byte is in SEND.
      repeat (5) @(negedge clk);
      err_idx = 0;
      echo_idx = 0;
      pulse_start();
      n = 0;
      while (!(sent_count == 16'd2 && tx_data_ready) && n < 20000) begin @(negedge clk); n++; end
      check_val("t4_err_rxerr", 32'(err_count), 32'd1);
      stray_rx = 1'b1;
      @(negedge clk);
      stray_rx = 1'b0;
      check_val("t4_err_stray", 32'(err_count), 32'd2);
      check_val("t4_rd_low0",   32'(rx_read), 32'd0);
      repeat (2) @(negedge clk);
      check_val("t4_rd_low1",   32'(rx_read), 32'd0);
      wait_done("t4");
      check_val("t4_err",  32'(err_count), 32'd2);
      check_val("t4_pass", 32'(pass), 32'd0);
      check_val("t4_sent", 32'(sent_count), 32'd4);
      err_idx = -1;

      // Reset while rx_read is high, then a clean run.
      repeat (5) @(negedge clk);
      echo_idx = 0;
      pulse_start();
      n = 0;
      while (!rx_read && n < 20000) begin @(negedge clk); n++; end
      check_val("t5_rd_high", 32'(rx_read), 32'd1);
      #2 rst = 1'b1;
      #1;
      check_val("t5_rd",       32'(rx_read), 32'd0);
      check_val("t5_tx_ready", 32'(tx_data_ready), 32'd0);
      check_val("t5_tx_trans", 32'(tx_transaction), 32'd0);
      check_val("t5_busy",     32'(busy), 32'd0);
      check_val("t5_done",     32'(done), 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      echo_idx = 0;
      pulse_start();
      wait_done("t5");
      check_seq("t5");
      check_val("t5_pass", 32'(pass), 32'd1);
      check_val("t5_sent", 32'(sent_count), 32'd4);
      check_val("t5_err",  32'(err_count), 32'd0);

      // Pattern wrap FF -> 00 on the second instance.
      @(negedge clk) w_start = 1'b1;
      @(negedge clk) w_start = 1'b0;
      n = 0;
      while (!w_done && n < 20000) begin @(negedge clk); n++; end
      check_val("t6_done", 32'(w_done), 32'd1);
      check_val("t6_tx0",  32'(w_log[0]), 32'hFF);
      check_val("t6_tx1",  32'(w_log[1]), 32'h00);
      check_val("t6_pass", 32'(w_pass), 32'd1);
      check_val("t6_sent", 32'(w_sent), 32'd2);
      check_val("t6_err",  32'(w_err), 32'd0);
      check_val("t6_last", 32'(w_last), 32'h01);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
